// File: rtl/branch_resolver.sv
// branch_resolver: in-order resolution of 2-bit predictor predictions.
//
// Holds every issued prediction in a circular queue and, in order, compares
// each one against the direction that execute reports. Every resolve produces
// a one-cycle training strobe (result/taken) for the predictor. A wrong
// prediction pulses mispredict, drops all younger queued predictions and
// closes issue for one recovery cycle (the FLUSH state).
//
// Optional feature macro: BRANCH_RESOLVER_STATS_EN builds the saturating
// resolve/mispredict counters. Without it stat_total and stat_miss read 0.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   issue_valid/pred      new prediction from the predictor
//   issue_ready           queue can accept an issue (RUN and not full)
//   resolve_valid/taken   execute resolved the oldest outstanding branch
//   result, taken         registered training strobe and actual outcome
//   mispredict            registered one-cycle wrong-prediction pulse
//   outstanding           number of queued, unresolved predictions
//   resolve_err           sticky: resolve seen with an empty queue
//   stat_total, stat_miss resolve / mispredict counters (optional)

module branch_resolver #(
   parameter int unsigned AW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          issue_valid,
   input  logic          issue_pred,
   output logic          issue_ready,
   input  logic          resolve_valid,
   input  logic          resolve_taken,
   output logic          result,
   output logic          taken,
   output logic          mispredict,
   output logic [AW:0]   outstanding,
   output logic          resolve_err,
   output logic [15:0]   stat_total,
   output logic [15:0]   stat_miss
);

   localparam int unsigned Depth = 2 ** AW;
   localparam logic [AW:0] DepthCnt = (AW + 1)'(Depth);

   typedef enum logic [0:0] {StRun, StFlush} state_e;

   state_e            state_q;
   logic [Depth-1:0]  pred_q;
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [AW:0]       count_q;

   logic issue_acc;
   logic res_acc;
   logic res_miss;

   // issue_ready looks only at the current state, never at a same-cycle resolve.
   assign issue_ready = (state_q == StRun) && (count_q < DepthCnt);
   assign issue_acc   = issue_valid && issue_ready;
   assign res_acc     = (state_q == StRun) && resolve_valid && (count_q != '0);
   assign res_miss    = res_acc && (pred_q[rd_ptr_q] != resolve_taken);

   assign outstanding = count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StRun;
         pred_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         result      <= 1'b0;
         taken       <= 1'b0;
         mispredict  <= 1'b0;
         resolve_err <= 1'b0;
      end else begin
         result     <= res_acc;
         taken      <= res_acc && resolve_taken;
         mispredict <= res_miss;

         if (state_q == StRun && resolve_valid && count_q == '0) begin
            resolve_err <= 1'b1;
         end

         // Writing the slot is harmless on a flush: the pointers are cleared.
         if (issue_acc) begin
            pred_q[wr_ptr_q] <= issue_pred;
         end

         if (res_miss) begin
            // Everything still queued is younger than the wrong branch.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= StFlush;
         end else begin
            if (issue_acc) begin
               wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (res_acc) begin
               rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (AW + 1)'(issue_acc) - (AW + 1)'(res_acc);
            state_q <= StRun;
         end
      end
   end

`ifdef BRANCH_RESOLVER_STATS_EN
   logic [15:0] total_q;
   logic [15:0] miss_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         total_q <= '0;
         miss_q  <= '0;
      end else begin
         if (res_acc && total_q != 16'hFFFF) begin
            total_q <= total_q + 16'd1;
         end
         if (res_miss && miss_q != 16'hFFFF) begin
            miss_q <= miss_q + 16'd1;
         end
      end
   end

   assign stat_total = total_q;
   assign stat_miss  = miss_q;
`else
   assign stat_total = 16'h0000;
   assign stat_miss  = 16'h0000;
`endif

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Tracks the predictions issued by the 2-bit saturating branch predictor and resolves each one, in order, against the actual branch outcome from execute. For every resolved branch it drives the predictor's training inputs: the `result` strobe and the `taken` outcome. On a misprediction it pulses a flush, discards all younger in-flight predictions and inserts a one-cycle recovery bubble. It sits between the fetch-side predictor and the execute stage.

## Interface
- `AW`, default 2: address width of the in-flight queue; depth = 2**AW entries.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `issue_valid`  in  1  a prediction was issued for a new branch this cycle.
- `issue_pred`  in  1  predicted direction, 1 = taken (the predictor's `prediction` output).
- `issue_ready`  out  1  queue can accept an issue.
- `resolve_valid`  in  1  execute resolved the oldest outstanding branch.
- `resolve_taken`  in  1  actual direction of that branch.
- `result`  out  1  one-cycle training strobe to the predictor.
- `taken`  out  1  actual outcome accompanying `result`.
- `mispredict`  out  1  one-cycle pulse: the resolved prediction was wrong.
- `outstanding`  out  AW+1  number of queued, unresolved predictions.
- `resolve_err`  out  1  sticky: a resolve arrived with the queue empty.
- `stat_total`  out  16  resolved-branch count (see Configuration).
- `stat_miss`  out  16  mispredict count (see Configuration).

## Operation
- Storage: circular queue of 2**AW one-bit predictions with write pointer, read pointer and count. Pointers wrap modulo 2**AW.
- FSM states:
  - RUN is the reset state.
  - FLUSH always lasts exactly one cycle, then the FSM returns to RUN.
- `issue_ready` = (state == RUN) && (count < 2**AW). It is combinational and depends only on the current state, never on a same-cycle resolve.
- Issue is accepted when `issue_valid && issue_ready`: `issue_pred` is written at the write pointer, the write pointer increments, and count increments.
- Resolve is accepted in RUN when `resolve_valid` is high and count > 0:
  - The head entry is compared with `resolve_taken`.
  - The read pointer increments and count decrements.
  - `result` <= 1 and `taken` <= `resolve_taken`. These are set for every resolve, correct or not.
  - On a mismatch, `mispredict` <= 1, and the FSM goes to FLUSH.
- Flush on mismatch:
  - Both pointers and count are cleared to 0.
  - A same-cycle accepted issue is discarded, because it is younger than the mispredicted branch.
- Issue and a correct resolve in the same cycle: both take effect and count is unchanged.
- `resolve_valid` with count == 0 in RUN: sets `resolve_err`, and no strobe is generated. `resolve_err` clears only on reset.
- `resolve_valid` in FLUSH: ignored silently.
- `result`, `taken` and `mispredict` are registered. They deassert the cycle after they are set unless a new resolve is accepted.
- Reset, including in the middle of operation:
  - Queue contents are discarded and count = 0.
  - State returns to RUN.
  - Pending strobes are cancelled.

## Timing
- Reset values:
  - `result`, `taken`, `mispredict`, `resolve_err` = 0.
  - `outstanding` = 0.
  - `stat_*` = 0.
  - `issue_ready` = 1.
- Issue-to-visible latency: `outstanding` updates one cycle after the accepting edge.
- Resolve latency: `result`, `taken` and `mispredict` are high for exactly the one cycle following the accepting edge.
- Mispredict bubble: `issue_ready` is 0 for exactly one cycle after the mispredicting edge, coincident with the `mispredict` pulse.
- Back-to-back resolves produce back-to-back `result` pulses, one per cycle.

## Configuration
- `BRANCH_RESOLVER_STATS_EN` defined:
  - `stat_total` increments on every accepted resolve.
  - `stat_miss` increments on every mispredict.
  - Both counters saturate at 16'hFFFF and are cleared by reset.
- Not defined: the counters are not built, and `stat_total` and `stat_miss` are tied to 0.

## Test plan
- Reset: deassert `rst_n` after 2 cycles. Required: `issue_ready` = 1, `outstanding` = 0, all strobes 0.
- In-order training: issue preds 1,0,1, then resolve 1,0,1 on consecutive cycles. Required: three consecutive `result` pulses with `taken` = 1,0,1, `mispredict` never asserted, `outstanding` 3→0.
- Full and wrap with AW=2: issue 4, then `issue_ready` = 0 and a 5th issue is ignored. Resolve 2, issue 2, then resolve all 4. Required: outcomes are checked in issue order across the pointer wrap.
- Mispredict flush: issue 1,1,1, then resolve 0 with a simultaneous issue. Required:
  - Next cycle: `mispredict` = 1, `result` = 1, `taken` = 0, `outstanding` = 0, `issue_ready` = 0.
  - The cycle after: `issue_ready` = 1.
- Empty resolve: with the queue empty, pulse `resolve_valid`. Required: `resolve_err` = 1 and stays set, no `result`. Then assert `rst_n` low. Required: `resolve_err` clears.
- Stats, built with `BRANCH_RESOLVER_STATS_EN`: 5 resolves including 2 mispredicts. Required: `stat_total` = 5, `stat_miss` = 2. Without the macro, both read 0.
